// File: rtl/pursuit_ram_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port among NUM_REQ requesters,
// with per-requester lock for uninterrupted bursts and one-hot tagged read responses.
module pursuit_ram_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clock,
  input  logic                             resetN,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ-1:0]               req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             ram_write_enable,
  output logic [ADDR_WIDTH-1:0]            ram_read_addr,
  output logic [ADDR_WIDTH-1:0]            ram_write_addr,
  output logic [DATA_WIDTH-1:0]            ram_wdata,
  input  logic [DATA_WIDTH-1:0]            ram_rdata
);

  localparam int unsigned NR = NUM_REQ;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [PW-1:0] idx_t;
  typedef enum logic [0:0] {FREE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                 state_q, state_d;
  idx_t                   ptr_q, ptr_d;
  idx_t                   owner_q, owner_d;
  logic [NUM_REQ-1:0]     rv1_q, rv1_d;
  logic [NUM_REQ-1:0]     rv2_q;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  raddr_q, raddr_d;
  logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;

  logic                   accept;
  idx_t                   win;

  // Grant selection: rotating priority from ptr when free, owner only when locked.
  always_comb begin
    int unsigned c;
    idx_t        cand;
    gnt    = '0;
    accept = 1'b0;
    win    = '0;
    c      = 0;
    cand   = '0;
    if (resetN) begin
      case (state_q)
        FREE: begin
          for (int unsigned k = 0; k < NR; k++) begin
            c = 32'(ptr_q) + k;
            if (c >= NR) c = c - NR;
            cand = idx_t'(c);
            if (!accept && req[cand]) begin
              accept = 1'b1;
              win    = cand;
            end
          end
          if (accept) gnt[win] = 1'b1;
        end
        LOCKED: begin
          if (req[owner_q]) begin
            accept       = 1'b1;
            win          = owner_q;
            gnt[owner_q] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    rv1_d   = '0;
    we_d    = 1'b0;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      FREE, LOCKED: ;
      default: state_d = FREE;
    endcase
    if (accept) begin
      ptr_d   = (win == idx_t'(NR - 1)) ? '0 : idx_t'(win + idx_t'(1));
      state_d = req_lock[win] ? LOCKED : FREE;
      owner_d = win;
      if (req_we[win]) begin
        we_d    = 1'b1;
        waddr_d = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_d = req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        raddr_d    = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
        rv1_d[win] = 1'b1;
      end
    end
  end

  // Tag pipeline tracks the RAM's one-cycle read latency behind the port register.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q <= FREE;
      ptr_q   <= '0;
      owner_q <= '0;
      rv1_q   <= '0;
      rv2_q   <= '0;
      we_q    <= 1'b0;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      rv1_q   <= rv1_d;
      rv2_q   <= rv1_q;
      we_q    <= we_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rvalid           = rv2_q;
  assign rdata            = ram_rdata;
  assign ram_write_enable = we_q;
  assign ram_read_addr    = raddr_q;
  assign ram_write_addr   = waddr_q;
  assign ram_wdata        = wdata_q;

endmodule

// File: tb/tb_pursuit_ram_arbiter.sv
// Directed bench for pursuit_ram_arbiter: vector table plus hand sequences for
// reset-with-reads-in-flight and a 16-read stream; includes a behavioural RAM.
module tb_pursuit_ram_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 6;
  localparam int DW   = 32;

  logic              clock;
  logic              resetN;
  logic [NREQ-1:0]   req, req_we, req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   gnt, rvalid;
  logic [DW-1:0]     rdata;
  logic              ram_write_enable;
  logic [AW-1:0]     ram_read_addr, ram_write_addr;
  logic [DW-1:0]     ram_wdata, ram_rdata;

  logic [DW-1:0]     mem [64];

  int n_tests = 0;
  int n_fail  = 0;

  pursuit_ram_arbiter #(.NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .resetN(resetN),
    .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_write_enable(ram_write_enable), .ram_read_addr(ram_read_addr),
    .ram_write_addr(ram_write_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory preload: word at address a holds 0xC0DE0000 | a.
  initial begin
    for (int a = 0; a < 64; a++) mem[a] = 32'hC0DE_0000 | 32'(a);
  end

  always @(posedge clock) begin
    if (ram_write_enable) mem[ram_write_addr] <= ram_wdata;
    ram_rdata <= mem[ram_read_addr];
  end

  typedef struct {
    logic [5:0]  base;
    logic [2:0]  rq, we, lk;
    logic [31:0] wd;
    logic [2:0]  gnt, rv;
    logic [31:0] rd;
    logic        wen;
    logic [5:0]  waddr;
    logic [31:0] wdx;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Lane i address = base ^ (i*16); lane i write data = wd ^ (i << 28).
  task automatic drive(input logic [5:0] base, input logic [2:0] r, input logic [2:0] w,
                       input logic [2:0] l, input logic [31:0] wd);
    req      = r;
    req_we   = w;
    req_lock = l;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW]  = base ^ 6'(i*16);
      req_wdata[i*DW +: DW] = wd ^ (32'(i) << 28);
    end
  endtask

  initial begin
    logic [31:0] exp_d;
    //            base   req     we      lock    wd            gnt     rv      rdata         wen   waddr wdata
    tbl[0]  = '{6'd1,  3'b111, 3'b000, 3'b000, 32'h0,        3'b001, 3'b000, 32'h0,        1'b0, 6'd0, 32'h0};
    tbl[1]  = '{6'd1,  3'b111, 3'b000, 3'b000, 32'h0,        3'b010, 3'b000, 32'h0,        1'b0, 6'd0, 32'h0};
    tbl[2]  = '{6'd1,  3'b111, 3'b000, 3'b000, 32'h0,        3'b100, 3'b001, 32'hC0DE0001, 1'b0, 6'd0, 32'h0};
    tbl[3]  = '{6'd1,  3'b111, 3'b000, 3'b000, 32'h0,        3'b001, 3'b010, 32'hC0DE0011, 1'b0, 6'd0, 32'h0};
    tbl[4]  = '{6'd1,  3'b111, 3'b000, 3'b000, 32'h0,        3'b010, 3'b100, 32'hC0DE0021, 1'b0, 6'd0, 32'h0};
    tbl[5]  = '{6'd1,  3'b111, 3'b000, 3'b000, 32'h0,        3'b100, 3'b001, 32'hC0DE0001, 1'b0, 6'd0, 32'h0};
    tbl[6]  = '{6'd0,  3'b000, 3'b000, 3'b000, 32'h0,        3'b000, 3'b010, 32'hC0DE0011, 1'b0, 6'd0, 32'h0};
    tbl[7]  = '{6'd0,  3'b000, 3'b000, 3'b000, 32'h0,        3'b000, 3'b100, 32'hC0DE0021, 1'b0, 6'd0, 32'h0};
    tbl[8]  = '{6'd21, 3'b010, 3'b010, 3'b000, 32'h2F800000, 3'b010, 3'b000, 32'h0,        1'b0, 6'd0, 32'h0};
    tbl[9]  = '{6'd5,  3'b001, 3'b000, 3'b000, 32'h0,        3'b001, 3'b000, 32'h0,        1'b1, 6'd5, 32'h3F800000};
    tbl[10] = '{6'd9,  3'b010, 3'b000, 3'b000, 32'h0,        3'b010, 3'b000, 32'h0,        1'b0, 6'd0, 32'h0};
    tbl[11] = '{6'd12, 3'b111, 3'b000, 3'b100, 32'h0,        3'b100, 3'b001, 32'h3F800000, 1'b0, 6'd0, 32'h0};
    tbl[12] = '{6'd12, 3'b111, 3'b000, 3'b100, 32'h0,        3'b100, 3'b010, 32'hC0DE0019, 1'b0, 6'd0, 32'h0};
    tbl[13] = '{6'd12, 3'b111, 3'b000, 3'b100, 32'h0,        3'b100, 3'b100, 32'hC0DE002C, 1'b0, 6'd0, 32'h0};
    tbl[14] = '{6'd12, 3'b111, 3'b000, 3'b000, 32'h0,        3'b100, 3'b100, 32'hC0DE002C, 1'b0, 6'd0, 32'h0};
    tbl[15] = '{6'd12, 3'b011, 3'b000, 3'b000, 32'h0,        3'b001, 3'b100, 32'hC0DE002C, 1'b0, 6'd0, 32'h0};
    tbl[16] = '{6'd3,  3'b010, 3'b000, 3'b010, 32'h0,        3'b010, 3'b100, 32'hC0DE002C, 1'b0, 6'd0, 32'h0};
    tbl[17] = '{6'd3,  3'b001, 3'b000, 3'b000, 32'h0,        3'b000, 3'b001, 32'hC0DE000C, 1'b0, 6'd0, 32'h0};
    tbl[18] = '{6'd3,  3'b001, 3'b000, 3'b000, 32'h0,        3'b000, 3'b010, 32'hC0DE0013, 1'b0, 6'd0, 32'h0};
    tbl[19] = '{6'd3,  3'b001, 3'b000, 3'b000, 32'h0,        3'b000, 3'b000, 32'h0,        1'b0, 6'd0, 32'h0};
    tbl[20] = '{6'd3,  3'b011, 3'b000, 3'b000, 32'h0,        3'b010, 3'b000, 32'h0,        1'b0, 6'd0, 32'h0};
    tbl[21] = '{6'd3,  3'b001, 3'b000, 3'b000, 32'h0,        3'b001, 3'b000, 32'h0,        1'b0, 6'd0, 32'h0};
    tbl[22] = '{6'd0,  3'b000, 3'b000, 3'b000, 32'h0,        3'b000, 3'b010, 32'hC0DE0013, 1'b0, 6'd0, 32'h0};
    tbl[23] = '{6'd0,  3'b000, 3'b000, 3'b000, 32'h0,        3'b000, 3'b001, 32'hC0DE0003, 1'b0, 6'd0, 32'h0};

    resetN = 1'b0;
    drive(6'd0, 3'b000, 3'b000, 3'b000, 32'h0);

    // Reset: grants suppressed while resetN is low, port registers cleared.
    @(negedge clock);
    drive(6'd1, 3'b111, 3'b000, 3'b000, 32'h0);
    #2 chk("reset gnt", 32'(gnt), 32'h0);
    @(negedge clock);
    #2;
    chk("reset gnt2", 32'(gnt), 32'h0);
    chk("reset rvalid", 32'(rvalid), 32'h0);
    chk("reset we", 32'(ram_write_enable), 32'h0);
    chk("reset raddr", 32'(ram_read_addr), 32'h0);
    chk("reset waddr", 32'(ram_write_addr), 32'h0);
    chk("reset wdata", ram_wdata, 32'h0);

    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      resetN = 1'b1;
      drive(tbl[i].base, tbl[i].rq, tbl[i].we, tbl[i].lk, tbl[i].wd);
      #2;
      chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
      chk($sformatf("v%0d ram_we", i), 32'(ram_write_enable), 32'(tbl[i].wen));
      if (tbl[i].rv != 3'b000) chk($sformatf("v%0d rdata", i), rdata, tbl[i].rd);
      if (tbl[i].wen) begin
        chk($sformatf("v%0d waddr", i), 32'(ram_write_addr), 32'(tbl[i].waddr));
        chk($sformatf("v%0d wdata", i), ram_wdata, tbl[i].wdx);
      end
    end

    // Reset with a locked read in flight: tags and lock dropped, ptr back to 0.
    @(negedge clock);
    drive(6'd3, 3'b010, 3'b000, 3'b010, 32'h0);
    #2 chk("rst_mid t gnt", 32'(gnt), 32'h2);
    @(negedge clock);
    resetN = 1'b0;
    drive(6'd3, 3'b001, 3'b000, 3'b000, 32'h0);
    #2 chk("rst_mid t+1 gnt", 32'(gnt), 32'h0);
    @(negedge clock);
    resetN = 1'b1;
    drive(6'd8, 3'b101, 3'b000, 3'b000, 32'h0);
    #2;
    chk("rst_mid t+2 rvalid", 32'(rvalid), 32'h0);
    chk("rst_mid t+2 gnt", 32'(gnt), 32'h1);
    chk("rst_mid t+2 raddr", 32'(ram_read_addr), 32'h0);
    chk("rst_mid t+2 waddr", 32'(ram_write_addr), 32'h0);
    chk("rst_mid t+2 wdata", ram_wdata, 32'h0);
    @(negedge clock);
    drive(6'd0, 3'b000, 3'b000, 3'b000, 32'h0);
    #2;
    chk("rst_mid t+3 rvalid", 32'(rvalid), 32'h0);
    chk("rst_mid t+3 gnt", 32'(gnt), 32'h0);
    @(negedge clock);
    #2;
    chk("rst_mid t+4 rvalid", 32'(rvalid), 32'h1);
    chk("rst_mid t+4 rdata", rdata, 32'hC0DE0008);

    // Single requester streams addresses 0..15; address 5 holds the earlier write.
    for (int k = 0; k < 18; k++) begin
      @(negedge clock);
      if (k < 16) drive(6'(k), 3'b001, 3'b000, 3'b000, 32'h0);
      else        drive(6'd0, 3'b000, 3'b000, 3'b000, 32'h0);
      #2;
      chk($sformatf("stream%0d gnt", k), 32'(gnt), (k < 16) ? 32'h1 : 32'h0);
      chk($sformatf("stream%0d rvalid", k), 32'(rvalid), (k >= 2) ? 32'h1 : 32'h0);
      if (k >= 2) begin
        exp_d = (k - 2 == 5) ? 32'h3F800000 : (32'hC0DE_0000 | 32'(k - 2));
        chk($sformatf("stream%0d rdata", k), rdata, exp_d);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pursuit_ram_arbiter.md
# pursuit_ram_arbiter

Round-robin arbiter that shares one single-clock synchronous RAM (dictionary, y or x store) among several pursuit-chip requesters, such as the host loader, sweep engine and residual updater. It accepts at most one read or write command per cycle and registers the winning command onto the RAM port. It returns read data with a one-hot valid tag so each requester identifies its own responses. A lock input lets one requester hold the RAM for an uninterrupted burst, such as streaming a dictionary column.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_WIDTH, DICTIONARY_ADDR_WIDTH, RAM address width
- DATA_WIDTH, 32, RAM data width (fp_32_t)

Ports:
- clock  in  1  clock
- resetN  in  1  reset resetN, synchronous, active-low; clock clock
- req  in  NUM_REQ  per-requester command request
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_lock  in  NUM_REQ  keep ownership after this command
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
- gnt  out  NUM_REQ  one-hot, combinational; req[i]&gnt[i] = command accepted this cycle
- rvalid  out  NUM_REQ  one-hot read-response tag
- rdata  out  DATA_WIDTH  read data, meaningful only when rvalid != 0
- ram_write_enable  out  1  to RAM write_enable
- ram_read_addr  out  ADDR_WIDTH  to RAM read_addr
- ram_write_addr  out  ADDR_WIDTH  to RAM write_addr
- ram_wdata  out  DATA_WIDTH  to RAM write-data input
- ram_rdata  in  DATA_WIDTH  from RAM read-data output; valid 1 cycle after read address

## Operation
- State: FREE or LOCKED(owner). Round-robin pointer `ptr` resets to 0.
- FREE:
  - gnt selects the first i with req[i]=1, scanning ptr, ptr+1, … mod NUM_REQ.
  - gnt is 0 when no requests are pending.
- Acceptance by requester i:
  - ptr <= (i+1) mod NUM_REQ.
  - If req_lock[i]=1, the state goes to LOCKED(i); otherwise it stays FREE.
- LOCKED(o):
  - gnt = req[o] ? onehot(o) : 0. Other requesters are never granted.
  - Acceptance with req_lock[o]=0 returns the state to FREE, and ptr <= (o+1) mod NUM_REQ.
  - If owner o deasserts req, it keeps ownership.
- Accepted write: registered ram_write_enable=1, ram_write_addr=addr, ram_wdata=data. No response is returned.
- Accepted read: registered ram_read_addr=addr, ram_write_enable=0. A tag onehot(i) enters a 2-stage valid pipeline.
- No accept: ram_write_enable=0. Addresses and data hold their previous values.
- rdata = ram_rdata, passed straight through.
- Commands reach the RAM in acceptance order. A read accepted the cycle after a write to the same address returns the new data; the arbiter does not forward data.
- Out-of-range requester index is impossible by construction. An illegal state is recovered to FREE.

## Timing
- Cycle t: req[i]=1 and gnt[i]=1, so the command is accepted at the end of cycle t.
- Cycle t+1: RAM port outputs carry the command.
- Cycle t+2: for a read, rvalid[i]=1 and rdata valid.
- Read latency is 2 cycles from acceptance. Throughput is 1 command per cycle with back-to-back reads fully pipelined.
- Reset (resetN=0 at an edge):
  - Outputs: ram_write_enable=0, ram_read_addr=0, ram_write_addr=0, ram_wdata=0, rvalid=0.
  - Internal state: FREE, ptr=0.
  - gnt is forced to 0 while resetN=0.
- Reset mid-burst or with reads in flight: lock is dropped and in-flight rvalid tags are discarded. No response appears after reset.
- Simultaneous requests: exactly one grant per cycle.
- A single persistent requester is granted every cycle.

## Test plan
- Reset, then req=3'b111 of reads held for 6 cycles:
  - gnt sequence is 001, 010, 100, 001, 010, 100.
  - rvalid follows the same sequence 2 cycles later with RAM contents of each address.
- Requester 1 writes 0x3F800000 to addr 5 at cycle t, requester 0 reads addr 5 at t+1: rvalid=001 at t+3 with rdata=0x3F800000.
- Requester 2 issues 4 reads with req_lock=1,1,1,0 while req[0] and req[1] are held:
  - gnt=100 for 4 consecutive cycles.
  - Then gnt=001, because ptr wrapped to 0.
- Locked owner 1 drops req for 3 cycles while req[0]=1: gnt=000 for those cycles. Owner resumes with lock=0, and requester 0 is granted the next cycle.
- Reads accepted at t and t+1, resetN=0 at t+1: rvalid stays 0 at t+2 and t+3. The first grant after reset goes to the lowest requesting index.
- Single requester 0 streams reads of addr 0..15: 16 consecutive grants and 16 consecutive rvalid=001 with data in address order.
